faiz_pencere: RTL and testbench

FAIZ_PENCERE -- requirements
Module: faiz_pencere

---
 rtl/faiz_pkg.sv | 15 +
 rtl/faiz_pencere_kaydirici.sv | 26 ++
 rtl/faiz_pencere.sv | 135 +++++++++++++
 tb/tb_faiz_pencere.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/faiz_pkg.sv
// rtl/faiz_pkg.sv - shared state encoding and constants for the rate window block
package faiz_pkg;

  // Controller phases: idle/accept, multiply, divide, finish
  typedef enum logic [1:0] {
    BOS   = 2'd0,
    CARP  = 2'd1,
    BOL   = 2'd2,
    SONUC = 2'd3
  } durum_t;

  // Percent base used by both the multiply and the divide phases
  localparam int YUZ = 100;

endpackage

// File: rtl/faiz_pencere_kaydirici.sv
// rtl/faiz_pencere_kaydirici.sv - N-entry sample window, newest entry at the top slot
module faiz_pencere_kaydirici #(
  parameter int ENF_W    = 4,
  parameter int DERINLIK = 3
) (
  input  logic                      saat,
  input  logic                      reset,
  input  logic                      kaydir,
  input  logic [ENF_W-1:0]          veri,
  output logic [DERINLIK*ENF_W-1:0] pencere
);

  logic [DERINLIK*ENF_W-1:0] pencere_q;

  // Shift toward slot 0 on each accepted sample; slot 0 (oldest) falls off
  always_ff @(posedge saat) begin
    if (reset) begin
      pencere_q <= '0;
    end else if (kaydir) begin
      pencere_q <= {veri, pencere_q[DERINLIK*ENF_W-1:ENF_W]};
    end
  end

  assign pencere = pencere_q;

endmodule

// File: rtl/faiz_pencere.sv
// rtl/faiz_pencere.sv - windowed compound-inflation interest rate; optional ceiling under FAIZ_TAVAN_EN
module faiz_pencere
  import faiz_pkg::*;
#(
  parameter int ENF_W    = 4,
  parameter int DERINLIK = 3,
  parameter int FAIZ_W   = 7,
  parameter int MARJ     = 2,
  parameter int TAVAN    = 50
) (
  input  logic              saat,
  input  logic              reset,
  input  logic              enf_gecerli,
  input  logic [ENF_W-1:0]  enf,
  output logic              enf_hazir,
  output logic [FAIZ_W-1:0] faiz,
  output logic              faiz_gecerli
);

  // Wide enough for the full N-term product of (100 + max sample)
  localparam int ACC_W = DERINLIK * $clog2(YUZ + (1 << ENF_W));

  durum_t                    durum_q, durum_d;
  logic [ACC_W-1:0]          acc_q, acc_d;
  logic [3:0]                sayac_q, sayac_d;
  logic [FAIZ_W-1:0]         faiz_q, faiz_d;
  logic                      faiz_gecerli_q, faiz_gecerli_d;

  logic                      kabul;
  logic                      hepsi_dolu;
  logic [DERINLIK*ENF_W-1:0] pencere;
  logic [ENF_W-1:0]          sec;
  logic [ACC_W-1:0]          deger;

  assign enf_hazir = (durum_q == BOS);
  assign kabul     = enf_gecerli && enf_hazir;

  faiz_pencere_kaydirici #(
    .ENF_W    (ENF_W),
    .DERINLIK (DERINLIK)
  ) u_kaydirici (
    .saat    (saat),
    .reset   (reset),
    .kaydir  (kabul),
    .veri    (enf),
    .pencere (pencere)
  );

  // Window after this accept would be slots 1..N-1 plus the incoming sample
  always_comb begin
    hepsi_dolu = (enf != '0);
    for (int i = 1; i < DERINLIK; i++) begin
      if (pencere[i*ENF_W +: ENF_W] == '0) hepsi_dolu = 1'b0;
    end
  end

  // Select the window entry for the current multiply step
  always_comb begin
    sec = '0;
    for (int i = 0; i < DERINLIK; i++) begin
      if (sayac_q == 4'(i)) sec = pencere[i*ENF_W +: ENF_W];
    end
  end

  // Final rate value: last two digits of the compounded percent plus margin
  always_comb begin
    deger = (acc_q % ACC_W'(YUZ)) + ACC_W'(MARJ);
`ifdef FAIZ_TAVAN_EN
    if (deger > ACC_W'(TAVAN)) deger = ACC_W'(TAVAN);
`endif
  end

  // Next-state and datapath updates for the multiply/divide sequence
  always_comb begin
    durum_d        = durum_q;
    acc_d          = acc_q;
    sayac_d        = sayac_q;
    faiz_d         = faiz_q;
    faiz_gecerli_d = 1'b0;
    case (durum_q)
      BOS: begin
        if (kabul && hepsi_dolu) begin
          durum_d = CARP;
          acc_d   = ACC_W'(1);
          sayac_d = '0;
        end
      end
      CARP: begin
        acc_d = acc_q * (ACC_W'(YUZ) + ACC_W'(sec));
        if (sayac_q == 4'(DERINLIK - 1)) begin
          durum_d = BOL;
          sayac_d = '0;
        end else begin
          sayac_d = sayac_q + 4'd1;
        end
      end
      BOL: begin
        acc_d = acc_q / ACC_W'(YUZ);
        if (sayac_q == 4'(DERINLIK - 2)) begin
          durum_d = SONUC;
          sayac_d = '0;
        end else begin
          sayac_d = sayac_q + 4'd1;
        end
      end
      SONUC: begin
        faiz_d         = FAIZ_W'(deger);
        faiz_gecerli_d = 1'b1;
        durum_d        = BOS;
      end
      default: durum_d = BOS;
    endcase
  end

  // State and datapath registers; reset aborts any computation in flight
  always_ff @(posedge saat) begin
    if (reset) begin
      durum_q        <= BOS;
      acc_q          <= '0;
      sayac_q        <= '0;
      faiz_q         <= '0;
      faiz_gecerli_q <= 1'b0;
    end else begin
      durum_q        <= durum_d;
      acc_q          <= acc_d;
      sayac_q        <= sayac_d;
      faiz_q         <= faiz_d;
      faiz_gecerli_q <= faiz_gecerli_d;
    end
  end

  assign faiz         = faiz_q;
  assign faiz_gecerli = faiz_gecerli_q;

endmodule

// File: tb/tb_faiz_pencere.sv
// tb/tb_faiz_pencere.sv - randomized and directed checks of faiz_pencere against a window model
module tb_faiz_pencere;

  localparam int ENF_W    = 4;
  localparam int DERINLIK = 3;
  localparam int FAIZ_W   = 7;
  localparam int MARJ     = 2;
  localparam int TAVAN    = 50;

  logic              saat = 1'b0;
  logic              reset = 1'b1;
  logic              enf_gecerli = 1'b0;
  logic [ENF_W-1:0]  enf = '0;
  logic              enf_hazir;
  logic [FAIZ_W-1:0] faiz;
  logic              faiz_gecerli;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference state: window as plain integers (index 0 oldest), last rate
  int  win [DERINLIK];
  int  model_faiz = 0;
  bit  model_fire = 1'b0;

  faiz_pencere #(
    .ENF_W    (ENF_W),
    .DERINLIK (DERINLIK),
    .FAIZ_W   (FAIZ_W),
    .MARJ     (MARJ),
    .TAVAN    (TAVAN)
  ) dut (
    .saat         (saat),
    .reset        (reset),
    .enf_gecerli  (enf_gecerli),
    .enf          (enf),
    .enf_hazir    (enf_hazir),
    .faiz         (faiz),
    .faiz_gecerli (faiz_gecerli)
  );

  always #5 saat = ~saat;

  function automatic int model_rate();
    longint p;
    longint d;
    longint r;
    int     v;
    p = 1;
    d = 1;
    for (int i = 0; i < DERINLIK; i++) p = p * (100 + win[i]);
    for (int i = 0; i < DERINLIK - 1; i++) d = d * 100;
    r = p / d;
    v = int'(r % 100) + MARJ;
`ifdef FAIZ_TAVAN_EN
    if (v > TAVAN) v = TAVAN;
`endif
    return v % (1 << FAIZ_W);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DERINLIK; i++) win[i] = 0;
    model_faiz = 0;
  endtask

  // Offer a sample, wait (bounded) for acceptance, update the model
  task automatic do_accept(input int v, input string name);
    int waited;
    bit all_nz;
    waited = 0;
    enf_gecerli = 1'b1;
    enf = ENF_W'(v);
    while (!enf_hazir && waited < 50) begin
      @(posedge saat); #1;
      waited++;
    end
    if (!enf_hazir) begin
      n_chk++;
      $display("FAIL %s accept_timeout: enf_hazir=%0b want 1", name, enf_hazir);
    end
    @(posedge saat); #1;
    enf_gecerli = 1'b0;
    for (int i = 0; i < DERINLIK - 1; i++) win[i] = win[i+1];
    win[DERINLIK-1] = v;
    all_nz = 1'b1;
    for (int i = 0; i < DERINLIK; i++) if (win[i] == 0) all_nz = 1'b0;
    model_fire = all_nz;
    if (all_nz) model_faiz = model_rate();
  endtask

  // Watch 2N+2 cycles after the accept edge: pulse position, ready, final rate
  task automatic observe(input bit exp_pulse, input string name);
    int pulses;
    int at;
    bit hazir_ok;
    pulses = 0;
    at = -1;
    hazir_ok = 1'b1;
    for (int c = 1; c <= 2*DERINLIK + 2; c++) begin
      @(posedge saat); #1;
      if (faiz_gecerli) begin
        pulses++;
        if (at < 0) at = c;
      end
      if (exp_pulse && c < 2*DERINLIK && enf_hazir) hazir_ok = 1'b0;
      if (!exp_pulse && !enf_hazir) hazir_ok = 1'b0;
      if (exp_pulse && c == 2*DERINLIK) begin
        n_chk++;
        if (faiz !== FAIZ_W'(model_faiz))
          $display("FAIL %s faiz_at_pulse: got %0d want %0d", name, faiz, model_faiz);
        else n_pass++;
      end
      if (c == 2*DERINLIK) enf_gecerli = 1'b0;
    end
    n_chk++;
    if (pulses !== (exp_pulse ? 1 : 0) || (exp_pulse && at !== 2*DERINLIK))
      $display("FAIL %s pulse: got count=%0d at=%0d want count=%0d at=%0d",
               name, pulses, at, exp_pulse ? 1 : 0, exp_pulse ? 2*DERINLIK : -1);
    else n_pass++;
    n_chk++;
    if (!hazir_ok)
      $display("FAIL %s enf_hazir: got wrong level during window want %0s",
               name, exp_pulse ? "low while busy" : "high throughout");
    else n_pass++;
    n_chk++;
    if (faiz !== FAIZ_W'(model_faiz))
      $display("FAIL %s faiz: got %0d want %0d", name, faiz, model_faiz);
    else n_pass++;
  endtask

  task automatic send(input int v, input string name);
    do_accept(v, name);
    observe(model_fire, name);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    enf_gecerli = 1'b1;
    enf = 4'd7;
    repeat (2) @(posedge saat);
    #1;
    reset = 1'b0;
    enf_gecerli = 1'b0;
    model_clear();
    n_chk++;
    if (faiz !== '0 || faiz_gecerli !== 1'b0 || enf_hazir !== 1'b1)
      $display("FAIL reset_state: got faiz=%0d vld=%0b hazir=%0b want 0 0 1",
               faiz, faiz_gecerli, enf_hazir);
    else n_pass++;
  endtask

  task automatic test_basic();
    send(5, "fill1");
    send(5, "fill2");
    send(5, "p555");
    n_chk++;
    if (faiz !== 7'd17) $display("FAIL p555_const: got %0d want 17", faiz);
    else n_pass++;
    send(9, "p559");
    n_chk++;
    if (faiz !== 7'd22) $display("FAIL p559_const: got %0d want 22", faiz);
    else n_pass++;
  endtask

  task automatic test_zero();
    send(0, "zero0");
    send(5, "zero5a");
    send(5, "zero5b");
  endtask

  task automatic test_high();
    send(15, "h1");
    send(15, "h2");
    send(15, "h15");
`ifdef FAIZ_TAVAN_EN
    n_chk++;
    if (faiz !== 7'd50) $display("FAIL h15_const: got %0d want 50", faiz);
    else n_pass++;
`else
    n_chk++;
    if (faiz !== 7'd54) $display("FAIL h15_const: got %0d want 54", faiz);
    else n_pass++;
`endif
  endtask

  // Valid stays high (with a changing value) while busy; only one shift may happen
  task automatic test_hold_valid();
    do_accept(3, "hold");
    enf_gecerli = 1'b1;
    enf = 4'd12;
    observe(model_fire, "hold");
    send(4, "hold_next");
  endtask

  task automatic test_reset_mid();
    send(5, "rm1");
    send(5, "rm2");
    send(5, "rm3");
    do_accept(7, "rm_go");
    repeat (4) @(posedge saat);
    #1;
    reset = 1'b1;
    @(posedge saat); #1;
    reset = 1'b0;
    model_clear();
    n_chk++;
    if (faiz !== '0 || faiz_gecerli !== 1'b0 || enf_hazir !== 1'b1)
      $display("FAIL reset_mid: got faiz=%0d vld=%0b hazir=%0b want 0 0 1",
               faiz, faiz_gecerli, enf_hazir);
    else n_pass++;
    observe(1'b0, "rm_quiet");
    send(9, "rm_single");
  endtask

  task automatic test_random();
    int v;
    for (int k = 0; k < 24; k++) begin
      v = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 15));
      send(v, "rand");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_high();
    test_hold_valid();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
